// File: rtl/game_tick_scheduler.sv
// Timing controller for the 8x8 LED ping-pong game: one shared prescaler feeds
// a fixed display scan enable and a level-dependent ball step enable, sequenced by the game phase FSM.
module game_tick_scheduler #(
    parameter logic [27:0] PRESCALE       = 28'd100000,
    parameter logic [9:0]  STEP_BASE      = 10'd320,
    parameter logic [9:0]  STEP_DEC       = 10'd32,
    parameter logic [2:0]  MAX_LEVEL      = 3'd7,
    parameter logic [3:0]  HITS_PER_LEVEL = 4'd4,
    parameter logic [9:0]  SERVE_TICKS    = 10'd500
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       HIT,
    input  logic       MISS,
    output logic       SCAN_TICK,
    output logic       STEP_TICK,
    output logic [2:0] LEVEL,
    output logic [1:0] STATE,
    output logic       RUNNING
);

    localparam int unsigned PRE_W = 28;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned LVL_W = 3;
    localparam int unsigned HIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SERVE  = 2'b01,
        ST_RALLY  = 2'b10,
        ST_PAUSED = 2'b11
    } state_t;

    state_t             state_q, state_d;
    state_t             saved_q, saved_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   serve_q, serve_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [HIT_W-1:0]   hit_q, hit_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               scan_q;
    logic               step_tick_q, step_tick_d;
    logic               running_q, running_d;

    logic               base_tick;
    logic [CNT_W-1:0]   period_m1;

    assign base_tick = (pre_q == PRESCALE - PRE_W'(1));
    assign pre_d     = base_tick ? '0 : pre_q + PRE_W'(1);

    // Period shrinks with level; the compare uses >= so a shortened period
    // that the running count already exceeds fires on the next base tick.
    assign period_m1 = STEP_BASE - CNT_W'(level_q) * STEP_DEC - CNT_W'(1);

    // Next-state and counter update
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        serve_d     = serve_q;
        step_d      = step_q;
        hit_d       = hit_q;
        level_d     = level_q;
        step_tick_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serve_d = '0;
                step_d  = '0;
                hit_d   = '0;
                level_d = '0;
                if (START) begin
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (MISS) begin
                    serve_d = '0;
                    step_d  = '0;
                    hit_d   = '0;
                    level_d = '0;
                end else if (PAUSE) begin
                    state_d = ST_PAUSED;
                    saved_d = ST_SERVE;
                end else if (base_tick) begin
                    if (serve_q == SERVE_TICKS - CNT_W'(1)) begin
                        state_d = ST_RALLY;
                        serve_d = '0;
                        step_d  = '0;
                    end else begin
                        serve_d = serve_q + CNT_W'(1);
                    end
                end
            end

            ST_RALLY: begin
                if (MISS) begin
                    state_d = ST_SERVE;
                    serve_d = '0;
                    step_d  = '0;
                    hit_d   = '0;
                    level_d = '0;
                end else if (PAUSE) begin
                    state_d = ST_PAUSED;
                    saved_d = ST_RALLY;
                end else begin
                    if (base_tick) begin
                        if (step_q >= period_m1) begin
                            step_d      = '0;
                            step_tick_d = 1'b1;
                        end else begin
                            step_d = step_q + CNT_W'(1);
                        end
                    end
                    if (HIT) begin
                        if (hit_q == HITS_PER_LEVEL - HIT_W'(1)) begin
                            hit_d = '0;
                            if (level_q < MAX_LEVEL) begin
                                level_d = level_q + LVL_W'(1);
                            end
                        end else begin
                            hit_d = hit_q + HIT_W'(1);
                        end
                    end
                end
            end

            ST_PAUSED: begin
                if (!PAUSE) begin
                    state_d = saved_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign running_d = (state_d == ST_SERVE) || (state_d == ST_RALLY);

    // State and counter registers
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            saved_q     <= ST_IDLE;
            pre_q       <= '0;
            serve_q     <= '0;
            step_q      <= '0;
            hit_q       <= '0;
            level_q     <= '0;
            scan_q      <= 1'b0;
            step_tick_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            pre_q       <= pre_d;
            serve_q     <= serve_d;
            step_q      <= step_d;
            hit_q       <= hit_d;
            level_q     <= level_d;
            scan_q      <= base_tick;
            step_tick_q <= step_tick_d;
            running_q   <= running_d;
        end
    end

    assign SCAN_TICK = scan_q;
    assign STEP_TICK = step_tick_q;
    assign LEVEL     = level_q;
    assign STATE     = state_q;
    assign RUNNING   = running_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with a small prescale so whole rallies
// fit in a few hundred cycles; expected cycle numbers are hand-computed.
module tb_game_tick_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       hit;
    logic       miss;
    logic       scan_tick;
    logic       step_tick;
    logic [2:0] level;
    logic [1:0] state;
    logic       running;

    int n_checks;
    int n_fail;
    int k;

    game_tick_scheduler #(
        .PRESCALE      (28'd4),
        .STEP_BASE     (10'd8),
        .STEP_DEC      (10'd1),
        .MAX_LEVEL     (3'd7),
        .HITS_PER_LEVEL(4'd2),
        .SERVE_TICKS   (10'd2)
    ) dut (
        .CLK_IN   (clk),
        .RST_N    (rst_n),
        .START    (start),
        .PAUSE    (pause),
        .HIT      (hit),
        .MISS     (miss),
        .SCAN_TICK(scan_tick),
        .STEP_TICK(step_tick),
        .LEVEL    (level),
        .STATE    (state),
        .RUNNING  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    // Advance to the next falling edge; k counts rising edges since reset release.
    task automatic cyc1();
        @(negedge clk);
        k++;
    endtask

    task automatic expect_step(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            cyc1();
            check(tag, 32'(step_tick), 32'(i == n));
        end
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cyc1();
        hit = 1'b0;
        cyc1();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        hit      = 1'b0;
        miss     = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_scan", 32'(scan_tick), 32'd0);
        check("rst_step", 32'(step_tick), 32'd0);
        check("rst_run", 32'(running), 32'd0);
        rst_n = 1'b1;
        k = 0;

        // Idle: scan every 4 cycles, nothing else
        for (int i = 1; i <= 12; i++) begin
            cyc1();
            check("idle_scan", 32'(scan_tick), 32'((k % 4) == 0));
            check("idle_step", 32'(step_tick), 32'd0);
            check("idle_state", 32'(state), 32'd0);
            check("idle_run", 32'(running), 32'd0);
        end

        // Serve for two base ticks, then rally with a 32-cycle step
        start = 1'b1;
        cyc1();
        start = 1'b0;
        check("serve_state", 32'(state), 32'd1);
        check("serve_run", 32'(running), 32'd1);
        while (k < 19) begin
            cyc1();
            check("serve_hold", 32'(state), 32'd1);
        end
        cyc1();
        check("rally_state", 32'(state), 32'd2);
        check("rally_run", 32'(running), 32'd1);
        expect_step(32, "step_l0_first");
        check("level0", 32'(level), 32'd0);
        expect_step(32, "step_l0_second");

        // Two hits: level 1, 28-cycle step
        hit = 1'b1;
        cyc1();
        hit = 1'b1;
        cyc1();
        hit = 1'b0;
        check("level1", 32'(level), 32'd1);
        expect_step(26, "step_l1_first");
        expect_step(28, "step_l1_second");

        // 14 more hits saturate at 7; two further hits leave it there
        for (int i = 0; i < 14; i++) pulse_hit();
        check("level7", 32'(level), 32'd7);
        pulse_hit();
        pulse_hit();
        check("level7_sat", 32'(level), 32'd7);
        expect_step(4, "step_l7_first");
        expect_step(4, "step_l7_second");

        // Miss back to serve, climb to level 3, then HIT+MISS together
        miss = 1'b1;
        cyc1();
        miss = 1'b0;
        check("miss_state", 32'(state), 32'd1);
        check("miss_level", 32'(level), 32'd0);
        while (k < 187) begin
            cyc1();
            check("reserve_hold", 32'(state), 32'd1);
        end
        cyc1();
        check("rerally_state", 32'(state), 32'd2);
        for (int i = 0; i < 6; i++) pulse_hit();
        check("level3", 32'(level), 32'd3);
        hit  = 1'b1;
        miss = 1'b1;
        cyc1();
        hit  = 1'b0;
        miss = 1'b0;
        check("hitmiss_state", 32'(state), 32'd1);
        check("hitmiss_level", 32'(level), 32'd0);
        while (k < 207) begin
            cyc1();
            check("hitmiss_serve", 32'(state), 32'd1);
        end
        cyc1();
        check("hitmiss_rally", 32'(state), 32'd2);
        expect_step(32, "step_after_miss");

        // Pause five base ticks into a step
        for (int i = 0; i < 20; i++) begin
            cyc1();
            check("prepause_step", 32'(step_tick), 32'd0);
        end
        pause = 1'b1;
        cyc1();
        check("pause_state", 32'(state), 32'd3);
        check("pause_run", 32'(running), 32'd0);
        for (int i = 0; i < 100; i++) begin
            cyc1();
            check("pause_step", 32'(step_tick), 32'd0);
            check("pause_scan", 32'(scan_tick), 32'((k % 4) == 0));
            check("pause_hold", 32'(state), 32'd3);
        end
        pause = 1'b0;
        cyc1();
        check("resume_state", 32'(state), 32'd2);
        check("resume_run", 32'(running), 32'd1);
        expect_step(10, "step_resume");

        // Asynchronous reset between edges
        pulse_hit();
        pulse_hit();
        check("prereset_level", 32'(level), 32'd1);
        check("prereset_scan", 32'(scan_tick), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_level", 32'(level), 32'd0);
        check("async_scan", 32'(scan_tick), 32'd0);
        check("async_step", 32'(step_tick), 32'd0);
        check("async_run", 32'(running), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cyc1();
            check("post_rst_state", 32'(state), 32'd0);
            check("post_rst_step", 32'(step_tick), 32'd0);
            check("post_rst_scan", 32'(scan_tick), 32'((k % 4) == 0));
        end
        start = 1'b1;
        cyc1();
        start = 1'b0;
        check("restart_state", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
